// File: rtl/secded_corrector.sv
// secded_corrector: parametrised two-stage SEC-DED decoder with valid/ready flow control.
// Saturating sec/ded counters are built only when SECDED_CORRECTOR_ERRCNT_EN is defined.
module secded_corrector #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned P0    = $clog2(DATA_W + 1),
    localparam int unsigned P     = ((2 ** P0) >= (DATA_W + P0 + 1)) ? P0 : P0 + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [P:0]        in_chk,
    input  logic              corr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sec,
    output logic              out_ded,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt
);

    localparam int unsigned N = DATA_W + P;

    // Codeword position of data bit j: the j-th non-power-of-two position from 3 upwards.
    function automatic int unsigned data_pos(int unsigned j);
        int unsigned cnt;
        int unsigned r;
        cnt = 0;
        r   = 0;
        for (int unsigned p = 3; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) r = p;
                cnt++;
            end
        end
        return r;
    endfunction

    logic              adv_c;
    logic [P-1:0]      syn_c;
    logic              par_c;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [P-1:0]      s1_syn;
    logic              s1_par;
    logic              s1_corr;

    logic [DATA_W-1:0] flip_c;
    logic [DATA_W-1:0] data_c;
    logic              sec_c;
    logic              ded_c;

    assign adv_c    = !out_valid || out_ready;
    assign in_ready = adv_c;

    // Syndrome: XOR of the positions of every set data and Hamming check bit.
    always_comb begin
        syn_c = '0;
        for (int unsigned i = 1; i <= P; i++) begin
            if (in_chk[i]) syn_c = syn_c ^ P'(1 << (i - 1));
        end
        for (int unsigned j = 0; j < DATA_W; j++) begin
            if (in_data[j]) syn_c = syn_c ^ P'(data_pos(j));
        end
    end

    assign par_c = ^{in_data, in_chk};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
            s1_corr  <= 1'b0;
        end else if (adv_c) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_syn  <= syn_c;
                s1_par  <= par_c;
                s1_corr <= corr_en;
            end
        end
    end

    // Classification; check-bit positions never match a data position, so no flip there.
    always_comb begin
        sec_c  = 1'b0;
        ded_c  = 1'b0;
        flip_c = '0;
        if (s1_syn == '0) begin
            sec_c = s1_par;
        end else if (!s1_par || (s1_syn > P'(N))) begin
            ded_c = 1'b1;
        end else begin
            sec_c = 1'b1;
            for (int unsigned j = 0; j < DATA_W; j++) begin
                if (s1_syn == P'(data_pos(j))) flip_c[j] = 1'b1;
            end
        end
        data_c = s1_corr ? (s1_data ^ flip_c) : s1_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sec   <= 1'b0;
            out_ded   <= 1'b0;
        end else if (adv_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= data_c;
                out_sec  <= sec_c;
                out_ded  <= ded_c;
            end
        end
    end

`ifdef SECDED_CORRECTOR_ERRCNT_EN
    logic fire_c;
    assign fire_c = out_valid && out_ready;

    // Counters step on the output handshake; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (fire_c) begin
            if (out_sec && (sec_cnt != '1)) sec_cnt <= sec_cnt + CNT_W'(1);
            if (out_ded && (ded_cnt != '1)) ded_cnt <= ded_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign sec_cnt        = '0;
    assign ded_cnt        = '0;
`endif

endmodule

// File: tb/tb_secded_corrector.sv
// Bench for secded_corrector: directed table, stall/counter/reset sequences and a
// randomized stream checked against a codeword-level reference model.
`timescale 1ns/1ps
module tb_secded_corrector;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;
    localparam int          NPOS   = 38;
    localparam int          CMAX   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_data = '0;
    logic [6:0]        in_chk = '0;
    logic              corr_en = 1'b1;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       out_data;
    logic              out_sec;
    logic              out_ded;
    logic              cnt_clr = 1'b0;
    logic [CNT_W-1:0]  sec_cnt;
    logic [CNT_W-1:0]  ded_cnt;

    secded_corrector #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chk(in_chk),
        .corr_en(corr_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sec(out_sec), .out_ded(out_ded),
        .cnt_clr(cnt_clr), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        sec;
        logic        ded;
    } exp_t;

    typedef struct packed {
        logic [31:0] d;
        logic [6:0]  c;
        logic        corr;
        logic [31:0] ed;
        logic        esec;
        logic        eded;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    int   m_sec = 0;
    int   m_ded = 0;
    bit   rand_rdy = 1'b0;
    bit   force_rdy = 1'b1;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_pow2(int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Reference: lay out the full codeword, locate the error, flip it, read data back out.
    function automatic exp_t model(logic [31:0] d, logic [6:0] c, logic corr);
        logic [NPOS:0] cw;
        int s, q, k, idx;
        exp_t e;
        cw = '0;
        cw[0] = c[0];
        k = 1;
        idx = 0;
        for (int p = 1; p <= NPOS; p++) begin
            if (is_pow2(p)) begin cw[p] = c[k]; k++; end
            else begin cw[p] = d[idx]; idx++; end
        end
        s = 0;
        q = 0;
        for (int p = 0; p <= NPOS; p++) if (cw[p]) begin s ^= p; q ^= 1; end
        e = '0;
        if (s == 0) e.sec = (q == 1);
        else if (q == 0 || s > NPOS) e.ded = 1'b1;
        else begin
            e.sec = 1'b1;
            if (corr) cw[s] = ~cw[s];
        end
        idx = 0;
        for (int p = 1; p <= NPOS; p++) if (!is_pow2(p)) begin e.data[idx] = cw[p]; idx++; end
        return e;
    endfunction

    function automatic logic [6:0] encode(logic [31:0] d);
        int s, idx;
        logic [6:0] c;
        s = 0;
        idx = 0;
        for (int p = 1; p <= NPOS; p++) if (!is_pow2(p)) begin
            if (d[idx]) s ^= p;
            idx++;
        end
        c[6:1] = 6'(s);
        c[0]   = ^{d, c[6:1]};
        return c;
    endfunction

    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
    end

    // Scoreboard and counter model, evaluated mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   fired;
        if (rst) begin
            sb.delete();
            m_sec = 0;
            m_ded = 0;
        end else begin
            check("sec_cnt", 64'(sec_cnt), 64'(m_sec));
            check("ded_cnt", 64'(ded_cnt), 64'(m_ded));
            fired = 1'b0;
            e = '0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    fired = 1'b1;
                    check("sb_data", 64'(out_data), 64'(e.data));
                    check("sb_flags", 64'({out_sec, out_ded}), 64'({e.sec, e.ded}));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_data, in_chk, corr_en));
`ifdef SECDED_CORRECTOR_ERRCNT_EN
            if (cnt_clr) begin
                m_sec = 0;
                m_ded = 0;
            end else if (fired) begin
                if (e.sec && m_sec < CMAX) m_sec++;
                if (e.ded && m_ded < CMAX) m_ded++;
            end
`endif
        end
    end

    task automatic push(input logic [31:0] d, input logic [6:0] c, input logic corr);
        bit ok;
        ok = 1'b0;
        in_data  = d;
        in_chk   = c;
        corr_en  = corr;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("push_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_out();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) check("out_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !out_valid;
        end
        if (!done) check("drain_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [6:0]  c;
        logic [38:0] v;
        logic [33:0] cap;
        int          ne, b1, b2, exp3, exp1;

        vecs[0] = {32'h0000_0000, 7'h00, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1] = {32'h0000_0001, 7'h00, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = {32'h0000_0001, 7'h00, 1'b0, 32'h0000_0001, 1'b1, 1'b0};
        vecs[3] = {32'h0000_0000, 7'h02, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4] = {32'h0000_0000, 7'h01, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[5] = {32'h0000_0003, 7'h00, 1'b1, 32'h0000_0003, 1'b0, 1'b1};
        vecs[6] = {32'h0000_0000, 7'h7F, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
        vecs[7] = {32'h8000_0000, 7'h00, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[8] = {32'h0400_0000, 7'h00, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[9] = {32'h0000_0000, 7'h40, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

`ifdef SECDED_CORRECTOR_ERRCNT_EN
        exp3 = 3;
        exp1 = 1;
`else
        exp3 = 0;
        exp1 = 0;
`endif

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_flags", 64'({out_sec, out_ded}), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_counters", 64'({sec_cnt, ded_cnt}), 64'(0));
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            push(vecs[i].d, vecs[i].c, vecs[i].corr);
            wait_out();
            check($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].ed));
            check($sformatf("vec%0d_sec", i), 64'(out_sec), 64'(vecs[i].esec));
            check($sformatf("vec%0d_ded", i), 64'(out_ded), 64'(vecs[i].eded));
            @(posedge clk);
            #1;
        end
        drain();

        // Backpressure: stall the head of a 5-word stream.
        push(32'hA5A5_0001, encode(32'hA5A5_0001), 1'b1);
        push(32'h0000_0010, 7'h00, 1'b1);
        force_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cap = {out_data, out_sec, out_ded};
        check("stall_valid", 64'(out_valid), 64'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_hold", 64'({out_valid, out_data, out_sec, out_ded}), 64'({1'b1, cap}));
        end
        @(posedge clk);
        #1;
        force_rdy = 1'b1;
        push(32'h1234_5678, encode(32'h1234_5678), 1'b1);
        push(32'h0000_0003, 7'h00, 1'b1);
        push(32'hFFFF_FFFF, encode(32'hFFFF_FFFF) ^ 7'h08, 1'b1);
        drain();

        // Randomized stream with random backpressure and occasional clears.
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            d  = $urandom;
            c  = encode(d);
            ne = $urandom_range(0, 3);
            v  = {c, d};
            b1 = $urandom_range(0, 38);
            if (ne >= 1) v[b1] = ~v[b1];
            if (ne == 2) begin
                b2 = (b1 + $urandom_range(1, 38)) % 39;
                v[b2] = ~v[b2];
            end
            if (ne == 3) v[38:32] = 7'($urandom);
            cnt_clr = ($urandom_range(0, 31) == 0);
            push(v[31:0], v[38:32], $urandom_range(0, 3) != 0);
            cnt_clr = 1'b0;
        end
        rand_rdy  = 1'b0;
        force_rdy = 1'b1;
        @(posedge clk);
        #1;
        drain();

        // Counter saturation and clear.
        pulse_clr();
        for (int i = 0; i < 5; i++) push(32'h0000_0001, 7'h00, 1'b1);
        drain();
        check("sat_sec_cnt", 64'(sec_cnt), 64'(exp3));
        check("sat_ded_cnt", 64'(ded_cnt), 64'(0));
        pulse_clr();
        @(negedge clk);
        check("clr_sec_cnt", 64'(sec_cnt), 64'(0));
        @(posedge clk);
        #1;
        push(32'h0000_0001, 7'h00, 1'b1);
        push(32'h0000_0003, 7'h00, 1'b1);
        drain();
        check("cnt_sec_one", 64'(sec_cnt), 64'(exp1));
        check("cnt_ded_one", 64'(ded_cnt), 64'(exp1));

        // Reset with two words in flight.
        push(32'h0000_0001, 7'h00, 1'b1);
        push(32'h0000_0003, 7'h00, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("inflight_valid", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_counters", 64'({sec_cnt, ded_cnt}), 64'(0));
        @(negedge clk);
        check("midrst_dropped", 64'(out_valid), 64'(0));
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/secded_corrector.md
# secded_corrector

- Parametrised, pipelined single-error-correct / double-error-detect (SEC-DED) decoder for protected data words; generalises the fixed 32-bit combinational SEC corrector to any data width.
- Adds double-error detection, valid/ready flow control and optional saturating error counters.
- Sits between ECC-protected storage or links and downstream consumers.

## Interface
Parameters:
- DATA_W, 32, data bits per word (≥4)
- P, derived localparam: smallest P with 2^P ≥ DATA_W+P+1 (6 for DATA_W=32)
- CNT_W, 16, error counter width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  DATA_W  received data
- in_chk  in  P+1  received check bits; [0] overall parity, [i] (1..P) Hamming bit at position 2^(i-1)
- corr_en  in  1  1: flip the erroneous data bit; 0: pass data unmodified, still flag
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  corrected data
- out_sec  out  1  single error found (corrected, or located in a check bit)
- out_ded  out  1  uncorrectable error; data passed unmodified
- cnt_clr  in  1  synchronous clear of both counters
- sec_cnt, ded_cnt  out  CNT_W each  error counters (see Configuration)

## Operation
- Code layout: codeword positions 1..DATA_W+P; powers of two hold check bits; data bit j occupies the j-th non-power-of-two position in ascending order (bit 0 → position 3).
- Syndrome s (P bits) = XOR of the positions of all set data and check bits 1..P. q = XOR of all in_data and all in_chk bits.
- Classification:
  - s=0, q=0: clean.
  - s=0, q=1: sec=1 (error in in_chk[0]).
  - s=power of two, q=1: sec=1 (check-bit error).
  - s=data position, q=1: sec=1; that data bit is flipped when corr_en=1.
  - s>DATA_W+P, q=1: ded=1.
  - s≠0, q=0: ded=1.
- sec and ded are never both 1. corr_en is sampled with in_data.
- Pipeline:
  - Stage 1 registers data, s, q and corr_en.
  - Stage 2 registers out_data and flags.
  - Both stages advance on adv = !out_valid || out_ready.
  - in_ready = adv; combinational path out_ready → in_ready is permitted.
  - Bubbles propagate as valid=0.

## Timing
- Latency: 2 cycles, accept edge to out_valid, when unstalled. Throughput: 1 word/cycle.
- Stall (out_valid=1, out_ready=0): out_data and flags hold stable; in_ready=0; stage 1 holds.
- Reset values:
  - out_valid=0, stage-1 valid=0
  - out_data=0, out_sec=0, out_ded=0
  - sec_cnt=0, ded_cnt=0
  - in_ready=1 on the first cycle after reset
- Reset mid-operation drops all in-flight words; no output handshake for them.
- Counters:
  - Increment on the output handshake (out_valid && out_ready) of a flagged word.
  - Saturate at 2^CNT_W−1.
  - cnt_clr has priority over a same-cycle increment.

## Configuration
- SECDED_CORRECTOR_ERRCNT_EN defined: sec_cnt/ded_cnt logic is present as specified.
- Undefined: the ports remain and are tied to 0; cnt_clr is ignored; no counter flops.

## Test plan
All scenarios use DATA_W=32, P=6, corr_en=1, out_ready=1 unless stated.
- Clean word: in_data=0x00000000, in_chk=0x00 → two cycles later out_data=0x00000000, sec=0, ded=0.
- Single data error, corr_en=1: in_data=0x00000001, in_chk=0x00 (s=3, q=1) → out_data=0x00000000, sec=1.
- Same word with corr_en=0 → out_data=0x00000001, sec=1.
- Check-bit errors, in_data=0:
  - in_chk=0x02 → sec=1, out_data=0.
  - in_chk=0x01 → sec=1.
- Uncorrectable errors:
  - in_data=0x00000003, in_chk=0x00 (s=6, q=0) → ded=1, out_data=0x00000003.
  - in_data=0, in_chk=0x7F (s=63, q=1, invalid position) → ded=1.
- Backpressure, counters and reset:
  - Stream 5 words with out_ready low for 3 cycles mid-stream → no loss or duplication; outputs stable while stalled.
  - With CNT_W=2, 5 single-error words → sec_cnt saturates at 3.
  - cnt_clr → 0.
  - rst asserted with 2 words in flight → out_valid=0 next cycle; counters=0.
